// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: segment bit positions,
// the active-high hex glyph table, the per-slot scan states and a width helper.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; b and d are lower-case.
  localparam logic [6:0] HEX2SEG [16] = '{
    7'b0111111, // 0
    7'b0000110, // 1
    7'b1011011, // 2
    7'b1001111, // 3
    7'b1100110, // 4
    7'b1101101, // 5
    7'b1111101, // 6
    7'b0000111, // 7
    7'b1111111, // 8
    7'b1101111, // 9
    7'b1110111, // A
    7'b1111100, // b
    7'b0111001, // C
    7'b1011110, // d
    7'b1111001, // E
    7'b1110001  // F
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX2SEG[i_nibble];

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Self-timed multiplexed scanner for N-digit 7-segment displays with a blanking
// gap at the start of every digit slot, PWM brightness and per-frame shadowing
// of all inputs so a frame never shows a mix of old and new values.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_BLANK | first BLANK_CYCLES of a slot; all anodes, segments, dp off
//  ST_DRIVE | rest of the slot; current digit lit when enabled and PWM on
module seven_seg_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_W     = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [4*NUM_DIGITS-1:0]               digit_data,
  input  logic [NUM_DIGITS-1:0]                 dp_mask,
  input  logic [NUM_DIGITS-1:0]                 digit_en,
  input  logic [BRIGHT_W-1:0]                   brightness,
  output logic [NUM_DIGITS-1:0]                 an,
  output logic [6:0]                            seg,
  output logic                                  dp,
  output logic [clog2_min1(NUM_DIGITS)-1:0]     digit_idx,
  output logic                                  frame_tick
);

  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int CNT_W = clog2_min1(PRESCALE);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  localparam scan_state_e ST_RESET = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  // Inactive pin levels; internal logic is active-high and inverted only here.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  logic [CNT_W-1:0]        r_slot_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [BRIGHT_W-1:0]     r_pwm_cnt;
  scan_state_e             r_state;
  logic                    r_wrap_d;

  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic [BRIGHT_W-1:0]     r_sh_bright;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [IDX_W-1:0]        r_idx_q;
  logic                    r_frame_tick;

  logic                    w_slot_wrap;
  logic                    w_frame_wrap;
  logic [CNT_W-1:0]        w_slot_next;
  logic                    w_pwm_on;
  logic                    w_lit;
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_hi;
  logic [6:0]              w_seg_hi;
  logic                    w_dp_hi;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_digit_idx == IDX_LAST);
  assign w_slot_next  = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;

  // Full scale bypasses the PWM compare so all-ones is a true 100% duty.
  assign w_pwm_on = (&r_sh_bright) ||
                    ((r_sh_bright != '0) && (r_pwm_cnt < r_sh_bright));
  assign w_lit    = (r_state == ST_DRIVE) && r_sh_en[r_digit_idx] && w_pwm_on;

  assign w_nibble = r_sh_data[{r_digit_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  assign w_an_hi  = w_lit ? (NUM_DIGITS'(1) << r_digit_idx) : '0;
  assign w_seg_hi = w_lit ? w_glyph : '0;
  assign w_dp_hi  = w_lit && r_sh_dp[r_digit_idx];

  // Slot/digit/PWM counters and the slot phase state, which tracks slot_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
      r_state     <= ST_RESET;
      r_wrap_d    <= 1'b0;
    end else begin
      r_slot_cnt <= w_slot_next;
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      r_wrap_d   <= w_frame_wrap;
      r_state    <= (w_slot_next < BLANK_END) ? ST_BLANK : ST_DRIVE;
      if (w_slot_wrap) begin
        r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end
    end
  end

  // Inputs are sampled only at the frame wrap so each frame is self-consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data   <= '0;
      r_sh_dp     <= '0;
      r_sh_en     <= '0;
      r_sh_bright <= '0;
    end else if (w_frame_wrap) begin
      r_sh_data   <= digit_data;
      r_sh_dp     <= dp_mask;
      r_sh_en     <= digit_en;
      r_sh_bright <= brightness;
    end
  end

  // Pin registers: one cycle behind the counters, polarity applied here only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_idx_q      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_hi ^ AN_OFF;
      r_seg        <= w_seg_hi ^ SEG_OFF;
      r_dp         <= w_dp_hi ^ DP_OFF;
      r_idx_q      <= r_digit_idx;
      r_frame_tick <= r_wrap_d;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign digit_idx  = r_idx_q;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Randomised bench for seven_seg_scan_mux with a cycle-count based reference.
module tb_seven_seg_scan_mux;

  localparam int N     = 4;
  localparam int P     = 8;
  localparam int B     = 2;
  localparam int BW    = 2;
  localparam int FRAME = N * P;

  // Active-high glyph for each hex value, {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   digit_data = '0;
  logic [N-1:0]  dp_mask = '0;
  logic [N-1:0]  digit_en = '0;
  logic [BW-1:0] brightness = '0;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic [1:0]    digit_idx;
  logic          frame_tick;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  seven_seg_scan_mux #(
    .NUM_DIGITS  (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B),
    .BRIGHT_W    (BW),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_data (digit_data),
    .dp_mask    (dp_mask),
    .digit_en   (digit_en),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference: pins after clock edge e reflect scan time t = e-1 since reset.
  int          m_e;
  logic [15:0] m_data;
  logic [3:0]  m_dpm;
  logic [3:0]  m_en;
  logic [1:0]  m_br;
  logic [11:0] m_pins;
  logic [1:0]  m_idx;
  logic        m_tick;

  function automatic logic [11:0] pins_at(input int t, input logic [15:0] d,
                                          input logic [3:0] dpm, input logic [3:0] en,
                                          input logic [1:0] br);
    int   slot;
    int   idx;
    int   pwm;
    bit   lit;
    logic [3:0] a_hi;
    logic [6:0] s_hi;
    logic       p_hi;
    logic [3:0] nib;
    slot = t % P;
    idx  = (t / P) % N;
    pwm  = t % (1 << BW);
    lit  = (slot >= B) && en[idx] && ((br == 2'd3) || (br != 0 && pwm < int'(br)));
    a_hi = '0;
    s_hi = '0;
    p_hi = 1'b0;
    nib  = d[idx*4 +: 4];
    if (lit) begin
      a_hi[idx] = 1'b1;
      s_hi      = GLYPH[nib];
      p_hi      = dpm[idx];
    end
    return ~{a_hi, s_hi, p_hi};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e    <= 0;
      m_data <= '0;
      m_dpm  <= '0;
      m_en   <= '0;
      m_br   <= '0;
      m_pins <= '1;
      m_idx  <= '0;
      m_tick <= 1'b0;
    end else begin
      m_e    <= m_e + 1;
      m_pins <= pins_at(m_e, m_data, m_dpm, m_en, m_br);
      m_idx  <= 2'((m_e / P) % N);
      m_tick <= (m_e > 0) && (m_e % FRAME == 0);
      if ((m_e + 1) % FRAME == 0) begin
        m_data <= digit_data;
        m_dpm  <= dp_mask;
        m_en   <= digit_en;
        m_br   <= brightness;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d, time %0t)", name, act, exp, m_e, $time);
    end
  endtask

  // Every-cycle comparison against the reference plus the one-anode rule.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pins", {19'd0, an, seg, dp}, {19'd0, m_pins});
      chk("digit_idx", {30'd0, digit_idx}, {30'd0, m_idx});
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
      chk("onehot_an", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    end
  end

  // Park on the falling edge that follows clock edge number target.
  task automatic at_edge(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_e < target && guard < 5000);
    if (m_e != target) begin
      vectors++;
      miscompares++;
      $display("FAIL at_edge: reached edge %0d expected %0d", m_e, target);
    end
  endtask

  initial begin
    int guard;
    digit_data = 16'h4321;
    digit_en   = 4'b1111;
    dp_mask    = 4'b0010;
    brightness = 2'd3;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Frame 1 blank because shadows start cleared.
    at_edge(32);
    chk("lit_frame1_an", {28'd0, an}, 32'hF);
    chk("lit_frame1_tick", {31'd0, frame_tick}, 32'd0);
    at_edge(33);
    chk("lit_tick", {31'd0, frame_tick}, 32'd1);
    chk("lit_blank_slot", {28'd0, an}, 32'hF);
    at_edge(35);
    chk("lit_d0", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b1111001});
    at_edge(43);
    chk("lit_d1", {20'd0, an, seg, dp}, {20'd0, 4'b1101, 7'b0100100, 1'b0});
    at_edge(51);
    chk("lit_d2", {20'd0, an, seg, dp}, {20'd0, 4'b1011, 7'b0110000, 1'b1});

    // Quarter duty: only pwm phase 0 lights.
    brightness = 2'd1;
    at_edge(67);
    chk("lit_pwm_off", {28'd0, an}, 32'hF);
    at_edge(69);
    chk("lit_pwm_on", {28'd0, an}, 32'hE);

    // Zero brightness for one frame, then a mid-frame data change.
    brightness = 2'd0;
    at_edge(110);
    digit_data = 16'hABCD;
    brightness = 2'd3;
    at_edge(115);
    chk("lit_hold_dark", {28'd0, an}, 32'hF);
    at_edge(131);
    chk("lit_new_data", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0100001});

    // Alternate digits disabled.
    digit_en = 4'b1010;
    repeat (2 * FRAME) @(negedge clk);

    // Random input churn at random cycles.
    for (int c = 0; c < 30 * FRAME; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: digit_data = 16'($urandom);
          1: dp_mask    = 4'($urandom);
          2: digit_en   = 4'($urandom);
          default: brightness = 2'($urandom);
        endcase
      end
    end

    // Async reset in the middle of a lit DRIVE phase.
    digit_en   = 4'b1111;
    brightness = 2'd3;
    repeat (2 * FRAME) @(negedge clk);
    guard = 0;
    while (((m_e - 1) % P) != 4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_reset_lit", {31'd0, (an != 4'hF)}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {28'd0, an}, 32'hF);
    chk("async_seg", {25'd0, seg}, 32'h7F);
    chk("async_dp", {31'd0, dp}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    at_edge(10);
    chk("post_reset_an", {28'd0, an}, 32'hF);
    chk("post_reset_idx", {30'd0, digit_idx}, 32'd1);
    repeat (2 * FRAME) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
